counter_scanner: RTL and testbench
==================================

// Module: counter_scanner
// PURPOSE
//  Downstream consumer of the 16:1 counter multiplexer. Drives its 4-bit select, samples the
//  selected 8-bit count and streams the 16 counts as one byte-serial frame over a valid/ready
//  link toward the host/display path. Frames go out on a start pulse, or back-to-back in continuous mode.
// PARAMETERS
//  W        8   count/byte width; must equal the mux data width
//  N_CH     16  channels per frame; select width = 4
//  GAP_CYC  64  idle cycles between frames in continuous mode (>=1)
// PORTS
//  clk          in   1  system clock, all logic rising-edge
//  reset        in   1  asynchronous, active-high reset
//  start        in   1  one-cycle request for one frame; ignored while busy
//  cont         in   1  continuous mode: re-arm after GAP_CYC idle cycles
//  counter_mux  in   W  selected count returned by the mux (combinational path)
//  mux_sel      out  4  select to the mux
//  tx_data      out  W  frame byte
//  tx_valid     out  1  tx_data valid
//  tx_ready     in   1  sink accepts when tx_valid & tx_ready on a rising edge
//  busy         out  1  high from frame accept until last byte handshaken
//  frame_done   out  1  one-cycle pulse on cycle after last byte accepted
// BEHAVIOUR
//  Reset (async, active-high): state IDLE, mux_sel=4'd15, tx_data=0, tx_valid=0, busy=0,
//   frame_done=0, channel index=0, gap counter=0.
//  Channel k (count k) is reached with mux_sel = 15-k; channels sent in order 0..15.
//  FSM: IDLE -> SELECT on start (or gap expiry when cont=1); SELECT drives mux_sel=15-k, 1 cycle
//   settle -> SAMPLE registers counter_mux into tx_data, asserts tx_valid -> SEND holds
//   tx_data/tx_valid stable until tx_ready; on handshake k<15: k++ -> SELECT; k=15 -> DONE.
//   DONE: pulse frame_done, busy=0 -> GAP if cont else IDLE. GAP counts GAP_CYC cycles -> SELECT
//   (k=0); cont dropping during GAP -> IDLE at once.
//  Latency: start to first tx_valid = 2 cycles; min frame = 16*3 cycles with tx_ready stuck high.
//  tx_valid never deasserts without a handshake; tx_data never changes while tx_valid & !tx_ready.
//  Count sampled at SAMPLE only; counts changing during SEND do not alter the held byte.
//  start in same cycle as DONE or during GAP: ignored (no double frame, no queueing).
//  start and cont both high in IDLE: one frame, then continuous.
//  Reset mid-frame: frame abandoned, outputs to reset values; no partial frame_done.
// CONFIGURATION
//  SCAN_CHECKSUM_EN defined: after channel 15, extra SEND of checksum byte = mod-2^W sum of
//   16 sampled counts; frame = 17 bytes; frame_done follows checksum handshake.
//  Not defined: frame = exactly 16 bytes, no accumulator logic.
// STRUCTURE
//  Shared package scope_pkg: FSM state encoding (IDLE,SELECT,SAMPLE,SEND,DONE,GAP,CSUM),
//   CH_COUNT=16, SEL_W=4, SEL_OF_CH0=4'd15 constants.
//  One sub-module: gap_timer (load/count-down/expire pulse, width clog2(GAP_CYC+1)).
// TESTING
//  Reset then start, tx_ready=1, counts k -> 8'h10+k: bytes 10..1F in order, mux_sel 15..0, one frame_done.
//  tx_ready low 5 cycles at channel 3 (8'h13): tx_valid and tx_data=8'h13 held 5 cycles, no skip/duplicate.
//  start pulsed while busy at channel 7: ignored, frame count stays 1, bytes unchanged.
//  cont=1, GAP_CYC=4: second frame's first tx_valid exactly 4+2 cycles after frame_done.
//  reset asserted at channel 9 mid-SEND: tx_valid=0, mux_sel=15, busy=0 same cycle; next start restarts at ch0.
//  SCAN_CHECKSUM_EN, all counts 8'hFF: 17th byte = 8'hF0; frame_done after 17th handshake.

Source files
------------

// File: rtl/scope_pkg.sv
// Shared definitions for the counter scanner: FSM state encoding, channel
// count, select width and the select value that reaches channel 0.
package scope_pkg;

   localparam int CH_COUNT = 16;
   localparam int SEL_W = 4;
   localparam logic [SEL_W-1:0] SEL_OF_CH0 = 4'd15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_SAMPLE,
      ST_SEND,
      ST_DONE,
      ST_GAP,
      ST_CSUM
   } state_t;

   // The mux is wired in reverse: channel k sits behind select 15-k.
   function automatic logic [SEL_W-1:0] selOfCh(input logic [SEL_W-1:0] ch);
      return SEL_OF_CH0 - ch;
   endfunction

endpackage

// File: rtl/gap_timer.sv
// Inter-frame gap timer: loads GAP_CYC, counts down to zero and flags the
// last counted cycle so the scanner can launch the next frame on that edge.
module gap_timer
   import scope_pkg::*;
#(
   parameter int GAP_CYC = 64,
   localparam int CW = $clog2(GAP_CYC + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   output logic expire_o
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Next count: reload on request, otherwise walk down and park at zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = CW'(GAP_CYC);
      end else if (count_q != '0) begin
         count_d = count_q - CW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire_o = (count_q == CW'(1));

endmodule

// File: rtl/counter_scanner.sv
// Counter scanner: walks the 16:1 counter mux, samples each count and ships
// the frame byte-serially over a valid/ready link. Optional feature macro:
// SCAN_CHECKSUM_EN appends a mod-2^W sum of the 16 sampled counts as byte 17.
module counter_scanner
   import scope_pkg::*;
#(
   parameter int W = 8,
   parameter int N_CH = CH_COUNT,
   parameter int GAP_CYC = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             cont,
   input  logic [W-1:0]     counter_mux,
   output logic [SEL_W-1:0] mux_sel,
   output logic [W-1:0]     tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             busy,
   output logic             frame_done
);

   state_t           state_q;
   logic [SEL_W-1:0] chIdx_q;
   logic [SEL_W-1:0] chIdx_d;
   logic [SEL_W-1:0] muxSel_q;
   logic [W-1:0]     txData_q;
   logic             txValid_q;
   logic             busy_q;
   logic             frameDone_q;
`ifdef SCAN_CHECKSUM_EN
   logic [W-1:0]     sum_q;
`endif

   logic lastCh;
   logic handshake;
   logic frameEnd;
   logic launch;
   logic gapExpire;

   assign chIdx_d   = chIdx_q + SEL_W'(1);
   assign lastCh    = (chIdx_q == SEL_W'(N_CH - 1));
   assign handshake = txValid_q & tx_ready;

`ifdef SCAN_CHECKSUM_EN
   assign frameEnd = (state_q == ST_CSUM) & handshake;
`else
   assign frameEnd = (state_q == ST_SEND) & handshake & lastCh;
`endif

   // A frame begins on start from idle, or when the gap runs out in continuous
   // mode; the gap is counted from the DONE cycle so DONE+GAP spans GAP_CYC.
   assign launch = ((state_q == ST_IDLE) & start) |
                   (((state_q == ST_DONE) | (state_q == ST_GAP)) & cont & gapExpire);

   gap_timer #(
      .GAP_CYC (GAP_CYC)
   ) uGapTimer (
      .clk      (clk),
      .reset    (reset),
      .load_i   (frameEnd),
      .expire_o (gapExpire)
   );

   // Scanner FSM with all link and mux outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         chIdx_q     <= '0;
         muxSel_q    <= SEL_OF_CH0;
         txData_q    <= '0;
         txValid_q   <= 1'b0;
         busy_q      <= 1'b0;
         frameDone_q <= 1'b0;
`ifdef SCAN_CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         frameDone_q <= 1'b0;
         if (launch) begin
            state_q  <= ST_SELECT;
            chIdx_q  <= '0;
            muxSel_q <= SEL_OF_CH0;
            busy_q   <= 1'b1;
`ifdef SCAN_CHECKSUM_EN
            sum_q    <= '0;
`endif
         end else if (frameEnd) begin
            state_q     <= ST_DONE;
            txValid_q   <= 1'b0;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b1;
            muxSel_q    <= SEL_OF_CH0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q <= ST_IDLE;
               end
               ST_SELECT: begin
                  state_q <= ST_SAMPLE;
               end
               ST_SAMPLE: begin
                  txData_q  <= counter_mux;
                  txValid_q <= 1'b1;
`ifdef SCAN_CHECKSUM_EN
                  sum_q     <= sum_q + counter_mux;
`endif
                  state_q   <= ST_SEND;
               end
               ST_SEND: begin
                  if (tx_ready) begin
                     if (!lastCh) begin
                        chIdx_q   <= chIdx_d;
                        muxSel_q  <= selOfCh(chIdx_d);
                        txValid_q <= 1'b0;
                        state_q   <= ST_SELECT;
                     end else begin
`ifdef SCAN_CHECKSUM_EN
                        txData_q  <= sum_q;
                        state_q   <= ST_CSUM;
`else
                        state_q   <= ST_DONE;
`endif
                     end
                  end
               end
`ifdef SCAN_CHECKSUM_EN
               ST_CSUM: begin
                  state_q <= ST_CSUM;
               end
`endif
               ST_DONE: begin
                  state_q <= cont ? ST_GAP : ST_IDLE;
               end
               ST_GAP: begin
                  if (!cont) begin
                     state_q <= ST_IDLE;
                  end
               end
               default: begin
                  state_q   <= ST_IDLE;
                  txValid_q <= 1'b0;
                  busy_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign mux_sel    = muxSel_q;
   assign tx_data    = txData_q;
   assign tx_valid   = txValid_q;
   assign busy       = busy_q;
   assign frame_done = frameDone_q;

endmodule

// File: tb/tb_counter_scanner.sv
// Testbench for counter_scanner with a behavioural mux and frame model.
module tb_counter_scanner;

   localparam int W = 8;
   localparam int NCH = 16;
   localparam int GAP = 4;
`ifdef SCAN_CHECKSUM_EN
   localparam int NBYTES = NCH + 1;
`else
   localparam int NBYTES = NCH;
`endif

   typedef logic [W-1:0] byteQ_t[$];

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         cont;
   logic         txReady;
   logic [W-1:0] counterMux;
   logic [3:0]   muxSel;
   logic [W-1:0] txData;
   logic         txValid;
   logic         busy;
   logic         frameDone;

   logic [W-1:0] cnt [NCH];
   int checks = 0;
   int failures = 0;

   logic [W-1:0] rxBytes[$];
   logic [3:0]   rxSels[$];
   int           framesSeen = 0;
   int           holdViol = 0;
   logic         prevValid = 1'b0;
   logic         prevReady = 1'b0;
   logic [W-1:0] prevData = '0;

   always #5 clk = ~clk;

   // Mux model: channel k answers on select 15-k.
   assign counterMux = cnt[4'd15 - muxSel];

   counter_scanner #(
      .W       (W),
      .N_CH    (NCH),
      .GAP_CYC (GAP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .cont        (cont),
      .counter_mux (counterMux),
      .mux_sel     (muxSel),
      .tx_data     (txData),
      .tx_valid    (txValid),
      .tx_ready    (txReady),
      .busy        (busy),
      .frame_done  (frameDone)
   );

   // Link monitor: records accepted bytes and catches unstable held bytes.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            prevValid = 1'b0;
         end else begin
            if (prevValid && !prevReady && (txValid !== 1'b1 || txData !== prevData)) holdViol++;
            if (txValid && txReady) begin
               rxBytes.push_back(txData);
               rxSels.push_back(muxSel);
            end
            if (frameDone) framesSeen++;
            prevValid = txValid;
            prevReady = txReady;
            prevData = txData;
         end
      end
   end

   // Reference frame: counts in channel order, plus their wrapped sum when enabled.
   function automatic byteQ_t modelFrame();
      byteQ_t q;
      int sum = 0;
      for (int k = 0; k < NCH; k++) begin
         q.push_back(cnt[k]);
         sum = sum + int'(cnt[k]);
      end
`ifdef SCAN_CHECKSUM_EN
      q.push_back(W'(sum % (1 << W)));
`endif
      return q;
   endfunction

   task automatic clearMonitor();
      rxBytes.delete();
      rxSels.delete();
      framesSeen = 0;
      holdViol = 0;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic applyStimulus(input logic [W-1:0] base);
      for (int k = 0; k < NCH; k++) cnt[k] = base + W'(k);
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; cont = 1'b0; txReady = 1'b0;
      applyStimulus(8'h10);
      #3;
      checks++; if (muxSel !== 4'd15) begin failures++; $display("[TB] FAIL reset_mux_sel got=%0d want=15", muxSel); end
      checks++; if (txData !== 8'h00) begin failures++; $display("[TB] FAIL reset_tx_data got=%h want=00", txData); end
      checks++; if (txValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_valid got=%b want=0", txValid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
      checks++; if (frameDone !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_done got=%b want=0", frameDone); end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic test_basic();
      byteQ_t exp;
      int n = 0;
      int lat = -1;
      logic busyMid = 1'b0;
      applyStimulus(8'h10);
      exp = modelFrame();
      txReady = 1'b1;
      clearMonitor();
      pulseStart();
      while (n < 500 && !frameDone) begin
         if (txValid && lat < 0) begin lat = n; busyMid = busy; end
         @(posedge clk); #1; n++;
      end
      checks++; if (lat !== 2) begin failures++; $display("[TB] FAIL basic_latency got=%0d want=2", lat); end
      checks++; if (busyMid !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy got=%b want=1", busyMid); end
      checks++; if (n !== 3 * NCH + (NBYTES - NCH)) begin failures++; $display("[TB] FAIL basic_frame_len got=%0d want=%0d", n, 3 * NCH + (NBYTES - NCH)); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_at_done got=%b want=0", busy); end
      repeat (3) @(posedge clk); #1;
      checks++; if (framesSeen !== 1) begin failures++; $display("[TB] FAIL basic_frames got=%0d want=1", framesSeen); end
      checks++; if (rxBytes.size() !== NBYTES) begin failures++; $display("[TB] FAIL basic_count got=%0d want=%0d", rxBytes.size(), NBYTES); end
      for (int i = 0; i < NBYTES && i < rxBytes.size(); i++) begin
         checks++; if (rxBytes[i] !== exp[i]) begin failures++; $display("[TB] FAIL basic_byte%0d got=%h want=%h", i, rxBytes[i], exp[i]); end
      end
      for (int i = 0; i < NCH && i < rxSels.size(); i++) begin
         checks++; if (rxSels[i] !== 4'(15 - i)) begin failures++; $display("[TB] FAIL basic_sel%0d got=%0d want=%0d", i, rxSels[i], 15 - i); end
      end
   endtask

   task automatic test_stall();
      byteQ_t exp;
      int n = 0;
      bit stalled = 0;
      applyStimulus(8'h10);
      exp = modelFrame();
      txReady = 1'b1;
      clearMonitor();
      pulseStart();
      while (n < 500 && !frameDone) begin
         if (!stalled && txValid && txData == 8'h13) begin
            txReady = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(posedge clk); #1; n++;
               checks++; if (txValid !== 1'b1 || txData !== 8'h13) begin failures++; $display("[TB] FAIL stall_hold%0d got=%b/%h want=1/13", i, txValid, txData); end
            end
            txReady = 1'b1;
            stalled = 1;
         end
         @(posedge clk); #1; n++;
      end
      checks++; if (!stalled || !frameDone) begin failures++; $display("[TB] FAIL stall_progress got=%0d/%b want=1/1", stalled, frameDone); end
      repeat (2) @(posedge clk); #1;
      checks++; if (rxBytes.size() !== NBYTES) begin failures++; $display("[TB] FAIL stall_count got=%0d want=%0d", rxBytes.size(), NBYTES); end
      for (int i = 0; i < NBYTES && i < rxBytes.size(); i++) begin
         checks++; if (rxBytes[i] !== exp[i]) begin failures++; $display("[TB] FAIL stall_byte%0d got=%h want=%h", i, rxBytes[i], exp[i]); end
      end
      checks++; if (holdViol !== 0) begin failures++; $display("[TB] FAIL stall_stability got=%0d want=0", holdViol); end
   endtask

   task automatic test_busy_start();
      byteQ_t exp;
      int n = 0;
      logic busyAtPulse = 1'b0;
      applyStimulus(8'h10);
      exp = modelFrame();
      txReady = 1'b1;
      clearMonitor();
      pulseStart();
      while (n < 500 && !frameDone) begin
         if (txValid && txData == 8'h17 && busyAtPulse == 1'b0) begin
            busyAtPulse = busy;
            pulseStart();
            n++;
         end
         @(posedge clk); #1; n++;
      end
      repeat (20) @(posedge clk); #1;
      checks++; if (busyAtPulse !== 1'b1) begin failures++; $display("[TB] FAIL busystart_busy got=%b want=1", busyAtPulse); end
      checks++; if (framesSeen !== 1) begin failures++; $display("[TB] FAIL busystart_frames got=%0d want=1", framesSeen); end
      checks++; if (rxBytes.size() !== NBYTES) begin failures++; $display("[TB] FAIL busystart_count got=%0d want=%0d", rxBytes.size(), NBYTES); end
      for (int i = 0; i < NBYTES && i < rxBytes.size(); i++) begin
         checks++; if (rxBytes[i] !== exp[i]) begin failures++; $display("[TB] FAIL busystart_byte%0d got=%h want=%h", i, rxBytes[i], exp[i]); end
      end
      checks++; if (busy !== 1'b0 || txValid !== 1'b0) begin failures++; $display("[TB] FAIL busystart_idle got=%b/%b want=0/0", busy, txValid); end
   endtask

   task automatic test_continuous();
      byteQ_t exp;
      int n = 0;
      for (int k = 0; k < NCH; k++) cnt[k] = W'($urandom);
      exp = modelFrame();
      txReady = 1'b1;
      cont = 1'b1;
      clearMonitor();
      pulseStart();
      while (n < 500 && !frameDone) begin @(posedge clk); #1; n++; end
      n = 0;
      while (n < 100 && !txValid) begin @(posedge clk); #1; n++; end
      checks++; if (n !== GAP + 2) begin failures++; $display("[TB] FAIL cont_gap got=%0d want=%0d", n, GAP + 2); end
      cont = 1'b0;
      n = 0;
      while (n < 500 && !frameDone) begin @(posedge clk); #1; n++; end
      repeat (30) @(posedge clk); #1;
      checks++; if (framesSeen !== 2) begin failures++; $display("[TB] FAIL cont_frames got=%0d want=2", framesSeen); end
      checks++; if (rxBytes.size() !== 2 * NBYTES) begin failures++; $display("[TB] FAIL cont_count got=%0d want=%0d", rxBytes.size(), 2 * NBYTES); end
      for (int i = 0; i < 2 * NBYTES && i < rxBytes.size(); i++) begin
         checks++; if (rxBytes[i] !== exp[i % NBYTES]) begin failures++; $display("[TB] FAIL cont_byte%0d got=%h want=%h", i, rxBytes[i], exp[i % NBYTES]); end
      end
      // Drop cont once the gap is running: no further frame may follow.
      cont = 1'b1;
      clearMonitor();
      pulseStart();
      n = 0;
      while (n < 500 && !frameDone) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      cont = 1'b0;
      repeat (3 * GAP + 20) @(posedge clk); #1;
      checks++; if (rxBytes.size() !== NBYTES || framesSeen !== 1) begin failures++; $display("[TB] FAIL cont_drop got=%0d/%0d want=%0d/1", rxBytes.size(), framesSeen, NBYTES); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL cont_drop_busy got=%b want=0", busy); end
   endtask

   task automatic test_reset_mid();
      byteQ_t exp;
      int n = 0;
      applyStimulus(8'h10);
      exp = modelFrame();
      txReady = 1'b1;
      clearMonitor();
      pulseStart();
      while (n < 500 && !(txValid && txData == 8'h19)) begin @(posedge clk); #1; n++; end
      txReady = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      checks++; if (txValid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_tx_valid got=%b want=0", txValid); end
      checks++; if (muxSel !== 4'd15) begin failures++; $display("[TB] FAIL rstmid_mux_sel got=%0d want=15", muxSel); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got=%b want=0", busy); end
      checks++; if (txData !== 8'h00) begin failures++; $display("[TB] FAIL rstmid_tx_data got=%h want=00", txData); end
      @(posedge clk); #1;
      reset = 1'b0;
      txReady = 1'b1;
      repeat (2) @(posedge clk); #1;
      checks++; if (framesSeen !== 0) begin failures++; $display("[TB] FAIL rstmid_no_done got=%0d want=0", framesSeen); end
      clearMonitor();
      pulseStart();
      n = 0;
      while (n < 500 && !frameDone) begin @(posedge clk); #1; n++; end
      repeat (2) @(posedge clk); #1;
      checks++; if (rxBytes.size() !== NBYTES) begin failures++; $display("[TB] FAIL rstmid_count got=%0d want=%0d", rxBytes.size(), NBYTES); end
      for (int i = 0; i < NBYTES && i < rxBytes.size(); i++) begin
         checks++; if (rxBytes[i] !== exp[i]) begin failures++; $display("[TB] FAIL rstmid_byte%0d got=%h want=%h", i, rxBytes[i], exp[i]); end
      end
   endtask

   task automatic test_saturated();
      byteQ_t exp;
      int n = 0;
      for (int k = 0; k < NCH; k++) cnt[k] = 8'hFF;
      exp = modelFrame();
      txReady = 1'b1;
      clearMonitor();
      pulseStart();
      while (n < 500 && !frameDone) begin @(posedge clk); #1; n++; end
      checks++; if (rxBytes.size() !== NBYTES) begin failures++; $display("[TB] FAIL sat_count_at_done got=%0d want=%0d", rxBytes.size(), NBYTES); end
      repeat (5) @(posedge clk); #1;
      checks++; if (rxBytes.size() !== NBYTES || framesSeen !== 1) begin failures++; $display("[TB] FAIL sat_count got=%0d/%0d want=%0d/1", rxBytes.size(), framesSeen, NBYTES); end
      for (int i = 0; i < NBYTES && i < rxBytes.size(); i++) begin
         checks++; if (rxBytes[i] !== exp[i]) begin failures++; $display("[TB] FAIL sat_byte%0d got=%h want=%h", i, rxBytes[i], exp[i]); end
      end
`ifdef SCAN_CHECKSUM_EN
      if (rxBytes.size() == NBYTES) begin
         checks++; if (rxBytes[NCH] !== 8'hF0) begin failures++; $display("[TB] FAIL sat_checksum got=%h want=F0", rxBytes[NCH]); end
      end
`endif
   endtask

   task automatic test_random();
      byteQ_t exp;
      int n;
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < NCH; k++) cnt[k] = W'($urandom);
         exp = modelFrame();
         txReady = 1'($urandom_range(0, 1));
         clearMonitor();
         pulseStart();
         n = 0;
         while (n < 2000 && !frameDone) begin
            @(posedge clk); #1; n++;
            txReady = 1'($urandom_range(0, 1));
            if (txValid) cnt[4'd15 - muxSel] = W'($urandom);
         end
         txReady = 1'b1;
         repeat (3) @(posedge clk); #1;
         checks++; if (!(n < 2000)) begin failures++; $display("[TB] FAIL rand%0d_timeout got=%0d want<2000", f, n); end
         checks++; if (rxBytes.size() !== NBYTES) begin failures++; $display("[TB] FAIL rand%0d_count got=%0d want=%0d", f, rxBytes.size(), NBYTES); end
         for (int i = 0; i < NBYTES && i < rxBytes.size(); i++) begin
            checks++; if (rxBytes[i] !== exp[i]) begin failures++; $display("[TB] FAIL rand%0d_byte%0d got=%h want=%h", f, i, rxBytes[i], exp[i]); end
         end
         checks++; if (holdViol !== 0) begin failures++; $display("[TB] FAIL rand%0d_stability got=%0d want=0", f, holdViol); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_busy_start();
      test_continuous();
      test_reset_mid();
      test_saturated();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
